// File: rtl/boxcar_interpolator.sv
// -----------------------------------------------------------------------------
// boxcar_interpolator
//
// Two-stage CIC interpolator by R = 2^LOG2R, normalised by R. Each accepted
// input sample x[n] produces a burst of R output samples that walk linearly
// from x[n-1] towards x[n]; the last sample of every burst equals x[n].
//
// Structure: two combs run at the input rate, the comb output is zero-stuffed
// by R, and two integrators run at the output rate. The final integrator is
// divided by R with an arithmetic right shift.
//
// Parameters
//   LOG2R     : log2 of the interpolation ratio (1..4)
//
// Ports
//   i_clk     : clock, rising edge
//   i_reset   : synchronous active-high reset
//   i_data    : signed 8-bit input sample
//   i_valid   : i_data is valid
//   o_ready   : block accepts i_data this cycle
//   o_data    : signed 8-bit interpolated sample (registered)
//   o_valid   : o_data is valid (registered)
//   i_ready   : downstream accepts o_data
//
// Build option
//   BOXCAR_INTERP_ROUND_EN : when defined, R/2 is added before the shift
//                            (round half toward +inf); otherwise the output
//                            is floored.
// -----------------------------------------------------------------------------
module boxcar_interpolator #(
    parameter int LOG2R = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic signed [7:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic signed [7:0] o_data,
    output logic              o_valid,
    input  logic              i_ready
);

    localparam int R = 1 << LOG2R;
    // Comb 2 spans +-510 and the last integrator reaches R*(-128); 10+LOG2R
    // bits covers both with margin, so nothing can wrap.
    localparam int W = 10 + LOG2R;

`ifdef BOXCAR_INTERP_ROUND_EN
    localparam logic signed [W-1:0] RND = W'(R / 2);
`else
    localparam logic signed [W-1:0] RND = '0;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t                  state_reg;
    logic [LOG2R-1:0]        phase_reg;
    logic signed [W-1:0]     hist_reg;        // x[n-1], first comb delay
    logic signed [W-1:0]     comb1_prev_reg;  // second comb delay
    logic signed [W-1:0]     integ1_reg;
    logic signed [W-1:0]     integ2_reg;
    logic signed [7:0]       data_reg;
    logic                    valid_reg;

    logic                    last_phase;
    logic                    in_fire;
    logic                    out_fire;
    logic signed [W-1:0]     x_ext;
    logic signed [W-1:0]     comb1;
    logic signed [W-1:0]     comb2;
    logic signed [W-1:0]     integ1_next;
    logic signed [W-1:0]     integ_step;
    logic signed [W-1:0]     acc_next;
    logic signed [W-1:0]     rounded;
    logic signed [7:0]       data_next;

    assign last_phase = (phase_reg == LOG2R'(R - 1));
    assign out_fire   = valid_reg && i_ready;

    // A new sample is taken either when idle, or in the same cycle the last
    // phase of the current burst is handed off, giving back-to-back bursts.
    always_comb begin
        o_ready = 1'b0;
        if (!i_reset) begin
            if (state_reg == IDLE) begin
                o_ready = 1'b1;
            end else begin
                o_ready = last_phase && i_ready;
            end
        end
    end

    assign in_fire = i_valid && o_ready;

    assign x_ext       = W'(i_data);
    assign comb1       = x_ext - hist_reg;
    assign comb2       = comb1 - comb1_prev_reg;
    assign integ1_next = integ1_reg + comb2;

    // The zero-stuffed comb output is non-zero only in the phase where a new
    // sample arrives; the first integrator absorbs it then holds.
    assign integ_step = in_fire ? integ1_next : integ1_reg;
    assign acc_next   = integ2_reg + integ_step;
    assign rounded    = acc_next + RND;
    assign data_next  = 8'(rounded >>> LOG2R);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg      <= IDLE;
            phase_reg      <= '0;
            hist_reg       <= '0;
            comb1_prev_reg <= '0;
            integ1_reg     <= '0;
            integ2_reg     <= '0;
            data_reg       <= '0;
            valid_reg      <= 1'b0;
        end else if (in_fire) begin
            state_reg      <= EMIT;
            phase_reg      <= '0;
            hist_reg       <= x_ext;
            comb1_prev_reg <= comb1;
            integ1_reg     <= integ1_next;
            integ2_reg     <= acc_next;
            data_reg       <= data_next;
            valid_reg      <= 1'b1;
        end else if (state_reg == EMIT && out_fire) begin
            if (!last_phase) begin
                phase_reg  <= phase_reg + LOG2R'(1);
                integ2_reg <= acc_next;
                data_reg   <= data_next;
            end else begin
                state_reg  <= IDLE;
                phase_reg  <= '0;
                valid_reg  <= 1'b0;
            end
        end
    end

    assign o_data  = data_reg;
    assign o_valid = valid_reg;

endmodule

// File: tb/tb_boxcar_interpolator.sv
// -----------------------------------------------------------------------------
// tb_boxcar_interpolator
//
// Drives boxcar_interpolator (LOG2R = 2) through directed and randomized
// sequences. A reference model keeps a queue of the outputs still owed for
// the current burst, computed straight from the linear-interpolation formula,
// and predicts o_valid, o_ready and o_data every cycle.
// -----------------------------------------------------------------------------
module tb_boxcar_interpolator;

    localparam int LOG2R = 2;
    localparam int R     = 1 << LOG2R;

    logic              i_clk = 1'b0;
    logic              i_reset = 1'b1;
    logic signed [7:0] i_data = '0;
    logic              i_valid = 1'b0;
    logic              o_ready;
    logic signed [7:0] o_data;
    logic              o_valid;
    logic              i_ready = 1'b0;

    int n_asserts = 0;
    int n_fail    = 0;

    logic signed [7:0] exp_q[$];
    int                x_prev   = 0;
    bit                zero_chk = 1'b0;

    always #5 i_clk = ~i_clk;

    boxcar_interpolator #(.LOG2R(LOG2R)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_asserts++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp_v));
        end
    endtask

    // Expected burst for a new sample x following x_prev.
    task automatic model_push(input int x);
        for (int p = 0; p < R; p++) begin
            int num;
            num = R * x_prev + (p + 1) * (x - x_prev);
`ifdef BOXCAR_INTERP_ROUND_EN
            num = num + R / 2;
`endif
            exp_q.push_back(8'(num >>> LOG2R));
        end
        x_prev = x;
    endtask

    // One clock cycle: drive inputs after the falling edge, check outputs,
    // then advance the model across the rising edge.
    task automatic step(input logic rst, input logic v, input logic signed [7:0] d,
                        input logic rdy, output bit ifire);
        bit ev, er, ofire;
        @(negedge i_clk);
        i_reset = rst;
        i_valid = v;
        i_data  = d;
        i_ready = rdy;
        #1;
        ev = (exp_q.size() > 0);
        er = !rst && (exp_q.size() == 0 || (exp_q.size() == 1 && rdy));
        check("o_valid", {7'd0, o_valid}, {7'd0, ev});
        check("o_ready", {7'd0, o_ready}, {7'd0, er});
        if (ev) check("o_data", o_data, exp_q[0]);
        if (zero_chk) begin
            check("o_data_reset", o_data, 8'd0);
            zero_chk = 1'b0;
        end
        ofire = ev && rdy;
        ifire = v && er;
        $display("t=%0t rst=%0d in_v=%0d in=%0d o_rdy=%0d o_v=%0d o_d=%0d dn_rdy=%0d",
                 $time, rst, v, d, o_ready, o_valid, o_data, rdy);
        @(posedge i_clk);
        if (rst) begin
            exp_q.delete();
            x_prev   = 0;
            zero_chk = 1'b1;
        end else begin
            if (ofire) void'(exp_q.pop_front());
            if (ifire) model_push(int'(d));
        end
    endtask

    // Hold a sample valid until it is accepted (bounded wait).
    task automatic push(input logic signed [7:0] x, input bit rnd_rdy);
        bit f;
        f = 1'b0;
        for (int k = 0; k < 64 && !f; k++) begin
            step(1'b0, 1'b1, x, rnd_rdy ? logic'($urandom_range(0, 1)) : 1'b1, f);
        end
        if (!f) check("push_timeout", 8'd0, 8'd1);
    endtask

    // Let the current burst finish (bounded wait).
    task automatic drain(input bit rnd_rdy);
        bit f;
        for (int k = 0; k < 64 && exp_q.size() > 0; k++) begin
            step(1'b0, 1'b0, 8'sd0, rnd_rdy ? logic'($urandom_range(0, 1)) : 1'b1, f);
        end
        if (exp_q.size() != 0) check("drain_timeout", 8'd0, 8'd1);
    endtask

    initial begin
        bit f;
        // Power-on reset; outputs are unknown until the first edge.
        @(posedge i_clk);
        @(posedge i_clk);
        zero_chk = 1'b1;
        step(1'b1, 1'b0, 8'sd0, 1'b1, f);
        step(1'b0, 1'b0, 8'sd0, 1'b1, f);

        // 0 then 100: 0,0,0,0 then 25,50,75,100
        push(8'sd0, 1'b0);
        push(8'sd100, 1'b0);
        drain(1'b0);
        step(1'b0, 1'b0, 8'sd0, 1'b1, f);

        // 0 then 10, 0 then -10 (rounding-sensitive values)
        push(8'sd0, 1'b0);
        push(8'sd10, 1'b0);
        drain(1'b0);
        push(8'sd0, 1'b0);
        push(-8'sd10, 1'b0);
        drain(1'b0);

        // Full-scale swings with valid held high: back-to-back bursts
        push(8'sd127, 1'b0);
        push(-8'sd128, 1'b0);
        push(8'sd127, 1'b0);
        drain(1'b0);

        // History survives a long idle gap
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 8'sd0, 1'b0, f);
        push(-8'sd50, 1'b0);
        drain(1'b0);

        // Random downstream stalls
        push(8'sd0, 1'b1);
        push(8'sd100, 1'b1);
        drain(1'b1);
        for (int k = 0; k < 30; k++) begin
            push(8'($urandom), 1'b1);
            if ($urandom_range(0, 3) == 0) drain(1'b1);
        end
        drain(1'b1);

        // Reset in the middle of the 0 -> 100 burst, at phase 1
        push(8'sd0, 1'b0);
        drain(1'b0);
        push(8'sd100, 1'b0);
        step(1'b0, 1'b0, 8'sd0, 1'b1, f);
        step(1'b1, 1'b0, 8'sd0, 1'b1, f);
        step(1'b0, 1'b0, 8'sd0, 1'b1, f);
        push(8'sd40, 1'b0);
        drain(1'b0);
        step(1'b0, 1'b0, 8'sd0, 1'b1, f);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
